pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum MEM_WAIT cycles without dmem_ack before the request is abandoned (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 stage2_inst  input  32  instruction currently in stage 2.
REQ-005 BrEq  input  1  branch comparator equal flag for stage-2 operands.
REQ-006 BrLT  input  1  branch comparator less-than flag; signedness already applied by the comparator.
REQ-007 dmem_ack  input  1  data memory completion pulse for the outstanding request.
REQ-008 pc_sel  output  1  1 = next PC is the stage-2 ALU result (taken branch or jump).
REQ-009 inst_kill  output  1  1 = stage-2 instruction is a squashed wrong-path instruction; it becomes a bubble with no writeback and no memory access.
REQ-010 stall  output  1  1 = hold PC, stage-1 and stage-2 registers.
REQ-011 dmem_req  output  1  single-cycle request strobe to data memory.
REQ-012 mem_err  output  1  sticky timeout flag.
REQ-013 stall_cnt  output  32  saturating count of cycles with stall=1.
REQ-014 flush_cnt  output  16  saturating count of taken control transfers.

Function
REQ-015 FSM states: RUN, MEM_WAIT, BR_FLUSH; all outputs are driven from state plus current inputs, with no additional output registers.
REQ-016 Decode uses stage2_inst[6:0] and [14:12]:
  - branch = 1100011;
  - jal = 1101111; jalr = 1100111;
  - load = 0000011; store = 0100011;
  - taken for branches: funct3 000 BrEq, 001 !BrEq, 100/110 BrLT, 101/111 !BrLT; other funct3 values are not taken.
  - jal and jalr are always taken.
REQ-017 RUN, load or store: dmem_req=1 and stall=1 this cycle; next state MEM_WAIT; wait counter cleared.
REQ-018 RUN, taken branch or jump: pc_sel=1 and stall=0 this cycle; next state BR_FLUSH; flush_cnt increments.
REQ-019 RUN, any other instruction: all strobes 0; remain in RUN.
REQ-020 MEM_WAIT, dmem_ack=0: stall=1, dmem_req=0 (no re-issue), wait counter increments.
REQ-021 MEM_WAIT, dmem_ack=1: stall=0 this cycle so the pipeline advances; next state RUN.
REQ-022 MEM_WAIT, wait counter reaches TIMEOUT with dmem_ack=0: stall=0 this cycle, mem_err set to 1, next state RUN.
REQ-023 If ack and timeout occur in the same cycle, the ack wins and mem_err is unchanged.
REQ-024 BR_FLUSH lasts exactly one cycle:
  - inst_kill=1, pc_sel=0, dmem_req=0, stall=0;
  - stage2_inst is ignored, even if it is a branch or load/store;
  - next state RUN.
REQ-025 dmem_ack while in RUN or BR_FLUSH is spurious and has no effect on any output or state.
REQ-026 pc_sel, dmem_req and inst_kill are mutually exclusive in every cycle.
REQ-027 stall_cnt increments in every cycle stall=1 and saturates at 0xFFFFFFFF; flush_cnt saturates at 0xFFFF.
REQ-028 mem_err is cleared only by rst.

Reset
REQ-029 rst=1 at a rising edge forces:
  - state RUN, wait counter 0;
  - mem_err=0, stall_cnt=0, flush_cnt=0.
REQ-030 While rst=1, pc_sel, inst_kill, stall and dmem_req are all 0, regardless of stage2_inst.
REQ-031 Reset during MEM_WAIT abandons the request without setting mem_err; an ack arriving after reset is ignored per REQ-025.
REQ-032 The first cycle after rst deasserts evaluates stage2_inst in RUN.

Verification
REQ-033 lw (0x0000A103), ack 3 cycles after req → dmem_req high for 1 cycle; stall high for 3 cycles, low in the ack cycle; stall_cnt=3.
REQ-034 beq (0x00208063) with BrEq=1 → pc_sel=1 for 1 cycle; next cycle inst_kill=1 with stage2_inst=sw held, and no dmem_req; flush_cnt=1.
REQ-035 bltu (funct3 110) with BrLT=0 → pc_sel=0, inst_kill=0, state remains RUN.
REQ-036 sw with TIMEOUT=4 and ack never asserted → stall high for 4 cycles, mem_err=1 after the 4th cycle, state RUN; a later ack has no effect.
REQ-037 Ack on the exact TIMEOUT cycle → mem_err stays 0.
REQ-038 rst asserted in the 2nd MEM_WAIT cycle → next cycle all outputs 0 and counters 0; a jal presented afterwards gives pc_sel=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: redirects on taken branches/jumps, squashes the
// wrong-path instruction, and stalls the pipeline while a load/store waits for
// data memory, abandoning the access after TIMEOUT wait cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | evaluate stage2_inst: issue memory request or take control flow
// MEM_WAIT | request outstanding; stall until ack or timeout
// BR_FLUSH | one cycle squashing the wrong-path instruction in stage 2
module pipe_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] stage2_inst,
  input  logic        BrEq,
  input  logic        BrLT,
  input  logic        dmem_ack,
  output logic        pc_sel,
  output logic        inst_kill,
  output logic        stall,
  output logic        dmem_req,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

  // Timeout fires on the TIMEOUT-th wait cycle, i.e. when the counter of
  // previously elapsed wait cycles equals TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_mem;
  logic        is_jump;
  logic        br_taken;
  logic        unused_inst_bits;

  assign opcode           = stage2_inst[6:0];
  assign funct3           = stage2_inst[14:12];
  assign unused_inst_bits = ^{stage2_inst[31:15], stage2_inst[11:7]};

  // Instruction decode and branch resolution for the stage-2 instruction.
  always_comb begin
    is_mem   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);
    br_taken = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        3'b000:          br_taken = BrEq;
        3'b001:          br_taken = !BrEq;
        3'b100, 3'b110:  br_taken = BrLT;
        3'b101, 3'b111:  br_taken = !BrLT;
        default:         br_taken = 1'b0;
      endcase
    end
  end

  // Next-state, output strobes and counter updates.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    pc_sel     = 1'b0;
    inst_kill  = 1'b0;
    stall      = 1'b0;
    dmem_req   = 1'b0;

    case (state_q)
      RUN: begin
        if (is_mem) begin
          dmem_req   = 1'b1;
          stall      = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = MEM_WAIT;
        end else if (br_taken || is_jump) begin
          pc_sel  = 1'b1;
          state_d = BR_FLUSH;
        end
      end
      MEM_WAIT: begin
        // Ack takes priority over a coincident timeout.
        if (dmem_ack) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          mem_err_d = 1'b1;
          state_d   = RUN;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      BR_FLUSH: begin
        inst_kill = 1'b1;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase

    // Strobes are forced quiet while reset is held.
    if (rst) begin
      pc_sel    = 1'b0;
      inst_kill = 1'b0;
      stall     = 1'b0;
      dmem_req  = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    flush_cnt_d = flush_cnt_q;
    if (pc_sel && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios followed by random instruction and
// ack traffic; a behavioural model predicts every cycle's outputs into a
// queue that an independent monitor drains at the falling edge.
module tb_pipe_ctrl;

  localparam int unsigned TO = 4;

  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BLTU = 32'h0020E063;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] stage2_inst;
  logic        BrEq, BrLT, dmem_ack;
  logic        pc_sel, inst_kill, stall, dmem_req, mem_err;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  pipe_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stage2_inst(stage2_inst), .BrEq(BrEq), .BrLT(BrLT),
    .dmem_ack(dmem_ack), .pc_sel(pc_sel), .inst_kill(inst_kill), .stall(stall),
    .dmem_req(dmem_req), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_sel;
    logic        inst_kill;
    logic        stall;
    logic        dmem_req;
    logic        mem_err;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Behavioural model: "is a memory access pending", "how many cycles it has
  // already waited", "is the next instruction a wrong-path one".
  bit      m_pending    = 0;
  int      m_waited     = 0;
  bit      m_squash_nxt = 0;
  bit      m_err        = 0;
  longint  m_stalls     = 0;
  int      m_flushes    = 0;

  function automatic bit is_taken(input logic [31:0] inst, input logic eq, input logic lt);
    logic [6:0] op;
    logic [2:0] f3;
    op = inst[6:0];
    f3 = inst[14:12];
    if (op == 7'b1101111 || op == 7'b1100111) return 1;
    if (op != 7'b1100011) return 0;
    case (f3)
      3'd0: return eq == 1'b1;   // beq
      3'd1: return eq == 1'b0;   // bne
      3'd4: return lt == 1'b1;   // blt
      3'd6: return lt == 1'b1;   // bltu
      3'd5: return lt == 1'b0;   // bge
      3'd7: return lt == 1'b0;   // bgeu
      default: return 0;
    endcase
  endfunction

  function automatic bit is_memop(input logic [31:0] inst);
    return inst[6:0] == 7'b0000011 || inst[6:0] == 7'b0100011;
  endfunction

  // Apply one cycle of inputs, predict the outputs, then advance the model.
  task automatic drive(input logic r, input logic [31:0] inst, input logic eq,
                       input logic lt, input logic ack);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stage2_inst = inst; BrEq = eq; BrLT = lt; dmem_ack = ack;
    cyc++;
    e.pc_sel = 0; e.inst_kill = 0; e.stall = 0; e.dmem_req = 0;
    e.mem_err   = m_err;
    e.stall_cnt = 32'(m_stalls);
    e.flush_cnt = 16'(m_flushes);
    if (r) begin
      m_pending = 0; m_waited = 0; m_squash_nxt = 0;
      m_err = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (m_squash_nxt) begin
        e.inst_kill = 1;
        m_squash_nxt = 0;
      end else if (m_pending) begin
        if (ack) m_pending = 0;
        else if (m_waited + 1 == int'(TO)) begin
          m_err = 1;
          m_pending = 0;
        end else begin
          e.stall = 1;
          m_waited++;
        end
      end else if (is_memop(inst)) begin
        e.dmem_req = 1; e.stall = 1;
        m_pending = 1; m_waited = 0;
      end else if (is_taken(inst, eq, lt)) begin
        e.pc_sel = 1;
        m_squash_nxt = 1;
        if (m_flushes < 65535) m_flushes++;
      end
      if (e.stall && m_stalls < 64'h0000_0000_FFFF_FFFF) m_stalls++;
    end
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one prediction per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_sel",    32'(pc_sel),    32'(e.pc_sel));
        chk("inst_kill", 32'(inst_kill), 32'(e.inst_kill));
        chk("stall",     32'(stall),     32'(e.stall));
        chk("dmem_req",  32'(dmem_req),  32'(e.dmem_req));
        chk("mem_err",   32'(mem_err),   32'(e.mem_err));
        chk("stall_cnt", stall_cnt,      e.stall_cnt);
        chk("flush_cnt", 32'(flush_cnt), 32'(e.flush_cnt));
      end
    end
  end

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [6:0]  op;
    logic [2:0]  f3;
    r  = $urandom;
    f3 = r[14:12];
    case ($urandom_range(0, 9))
      0:       op = 7'b0000011;
      1:       op = 7'b0100011;
      2, 3, 4: op = 7'b1100011;
      5:       op = 7'b1101111;
      6:       op = 7'b1100111;
      7:       op = 7'b0010011;
      8:       op = r[6:0];
      default: op = 7'b0110011;
    endcase
    return {r[31:15], f3, r[11:7], op};
  endfunction

  initial begin
    rst = 1; stage2_inst = I_NOP; BrEq = 0; BrLT = 0; dmem_ack = 0;

    // Reset, with a jump presented to show outputs stay quiet.
    drive(1, I_NOP, 0, 0, 0);
    drive(1, I_JAL, 0, 0, 1);

    // Load acked three cycles after the request.
    drive(0, I_LW,  0, 0, 0);
    drive(0, I_NOP, 0, 0, 0);
    drive(0, I_NOP, 0, 0, 0);
    drive(0, I_NOP, 0, 0, 1);
    drive(0, I_NOP, 0, 0, 0);

    // Taken beq, then the held store is squashed without a request.
    drive(0, I_BEQ, 1, 0, 0);
    drive(0, I_SW,  0, 0, 0);
    drive(0, I_NOP, 0, 0, 0);

    // Not-taken bltu.
    drive(0, I_BLTU, 1, 0, 0);
    drive(0, I_NOP,  0, 0, 0);

    // Store that never gets acked, then a late spurious ack.
    drive(0, I_SW, 0, 0, 0);
    for (int i = 0; i < int'(TO); i++) drive(0, I_NOP, 0, 0, 0);
    drive(0, I_NOP, 0, 0, 1);
    drive(0, I_NOP, 0, 0, 0);

    // Ack landing on the timeout cycle.
    drive(1, I_NOP, 0, 0, 0);
    drive(0, I_SW, 0, 0, 0);
    for (int i = 0; i < int'(TO) - 1; i++) drive(0, I_NOP, 0, 0, 0);
    drive(0, I_NOP, 0, 0, 1);
    drive(0, I_NOP, 0, 0, 0);

    // Reset in the second wait cycle, late ack, then a jump.
    drive(0, I_LW,  0, 0, 0);
    drive(0, I_NOP, 0, 0, 0);
    drive(1, I_LW,  0, 0, 0);
    drive(0, I_JAL, 0, 0, 1);
    drive(0, I_NOP, 0, 0, 0);
    drive(0, I_NOP, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), rand_inst(), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
